// File: rtl/ad7383_pkg.sv
// ad7383_pkg: shared sample width, packed A/B word type and packer state encoding.
package ad7383_pkg;
    localparam int AD7383_SAMPLE_W = 16;
    localparam int AD7383_MAX_DECIM_LOG2 = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    typedef struct packed {
        logic [AD7383_SAMPLE_W-1:0] a;
        logic [AD7383_SAMPLE_W-1:0] b;
    } word_t;
endpackage

// File: rtl/ad7383_word_fifo.sv
// ad7383_word_fifo: synchronous FIFO; the head word is read straight out of the storage flops.
module ad7383_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic do_rd, do_wr;

    always_comb begin
        do_rd = rd_en_i && count_q != '0;
        do_wr = wr_en_i && (count_q != FULL || do_rd);
        mem_d = mem_q;
        if (do_wr) mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o = count_q == FULL;
    assign empty_o = count_q == '0;
    assign count_o = count_q;
endmodule

// File: rtl/ad7383_sample_packer.sv
// ad7383_sample_packer: boxcar-decimates AD7383 A/B samples, packs them into words and buffers them for a valid/ready sink.
// Define AD7383_DROP_COUNT_EN to add the saturating drop_count_o port.
module ad7383_sample_packer
    import ad7383_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_DECIM_LOG2 = AD7383_MAX_DECIM_LOG2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        adc_ready_i,
    input  logic [2:0]  decim_i,
    input  logic [15:0] dataA_i,
    input  logic [15:0] dataB_i,
    input  logic        valid_i,
    input  logic        clear_ovf_i,
    output logic [31:0] m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        overflow_o,
`ifdef AD7383_DROP_COUNT_EN
    output logic [15:0] drop_count_o,
`endif
    output logic        busy_o
);
    localparam int ACC_W = AD7383_SAMPLE_W + MAX_DECIM_LOG2;
    localparam int CNT_W = MAX_DECIM_LOG2;
    localparam logic [2:0] DECIM_MAX = 3'(MAX_DECIM_LOG2);

    state_e state_q, state_d;
    logic [2:0] decim_q, decim_d;
    logic signed [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, sum_a, sum_b;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
    logic wr_q, wr_d, ovf_q, ovf_d;
    word_t word_q, word_d;
    logic fifo_full, fifo_empty, rd, drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_comb begin
        sum_a = acc_a_q + ACC_W'(signed'(dataA_i));
        sum_b = acc_b_q + ACC_W'(signed'(dataB_i));
        last_cnt = ~({CNT_W{1'b1}} << decim_q);
        state_d = state_q;
        decim_d = decim_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        cnt_d = cnt_q;
        wr_d = 1'b0;
        word_d = word_q;
        case (state_q)
            ST_IDLE: if (enable_i && adc_ready_i) begin
                state_d = ST_RUN;
                decim_d = decim_i > DECIM_MAX ? DECIM_MAX : decim_i;
                acc_a_d = '0;
                acc_b_d = '0;
                cnt_d = '0;
            end
            ST_RUN: if (!enable_i || !adc_ready_i) begin
                state_d = ST_DRAIN;
            end else if (valid_i && cnt_q == last_cnt) begin
                wr_d = 1'b1;
                word_d = '{a: AD7383_SAMPLE_W'(sum_a >>> decim_q), b: AD7383_SAMPLE_W'(sum_b >>> decim_q)};
                acc_a_d = '0;
                acc_b_d = '0;
                cnt_d = '0;
            end else if (valid_i) begin
                acc_a_d = sum_a;
                acc_b_d = sum_b;
                cnt_d = cnt_q + CNT_W'(1);
            end
            // a word still in the write register counts as in flight
            ST_DRAIN: if (fifo_count == '0 && !wr_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rd = m_tvalid_o && m_tready_i;
        drop = wr_q && fifo_full && !rd;
        ovf_d = drop || (ovf_q && !clear_ovf_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            decim_q <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            cnt_q <= '0;
            wr_q <= 1'b0;
            word_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            decim_q <= decim_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            cnt_q <= cnt_d;
            wr_q <= wr_d;
            word_q <= word_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef AD7383_DROP_COUNT_EN
    logic [15:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = clear_ovf_i ? 16'(drop) : dcnt_q + 16'(drop && dcnt_q != 16'hFFFF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) dcnt_q <= '0;
        else dcnt_q <= dcnt_d;
    end

    assign drop_count_o = dcnt_q;
`endif

    ad7383_word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (wr_q),
        .wr_data_i(word_q),
        .rd_en_i  (rd),
        .rd_data_o(m_tdata_o),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign m_tvalid_o = !fifo_empty;
    assign overflow_o = ovf_q;
    assign busy_o = state_q != ST_IDLE;
endmodule

// File: doc/ad7383_sample_packer.md
Name: ad7383_sample_packer

Overview:
- Downstream stage of the AD7383 ADC interface; consumes its paired 16-bit channel A/B samples and single-cycle valid strobe.
- Optionally decimates by boxcar averaging, packs A/B into one 32-bit word and buffers it in a small FIFO.
- Presents words to the system capture FIFO over a valid/ready handshake; flags overflow when downstream stalls.
- Runs in the 80 MHz ADC clock domain.

Parameters:
- FIFO_DEPTH, 4, word buffer depth; power of two, minimum 2.
- MAX_DECIM_LOG2, 4, largest supported log2 decimation ratio; sets accumulator width to 16+MAX_DECIM_LOG2.

Ports:
- clk_i  in  1  system clock (80 MHz, same as ADC interface).
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  capture enable from control logic.
- adc_ready_i  in  1  ADC interface initialised (its ready output).
- decim_i  in  3  log2 decimation ratio, 0..MAX_DECIM_LOG2; latched on entering Run.
- dataA_i  in  16  channel A sample, two's complement.
- dataB_i  in  16  channel B sample, two's complement.
- valid_i  in  1  one-cycle strobe; dataA_i/dataB_i are valid only in that cycle.
- clear_ovf_i  in  1  clears overflow_o.
- m_tdata_o  out  32  {avgA[15:0], avgB[15:0]}.
- m_tvalid_o  out  1  word available.
- m_tready_i  in  1  downstream accepts; a transfer occurs when valid and ready are both high.
- overflow_o  out  1  sticky: at least one word was dropped.
- busy_o  out  1  state is not Idle.

Behaviour:
- Reset: state Idle; accumulators, count and FIFO cleared; m_tvalid_o=0, m_tdata_o=0, overflow_o=0, busy_o=0.
- FSM states: Idle, Run, Drain.
  - Idle -> Run when enable_i & adc_ready_i. Latch decim_i, clamping values >MAX_DECIM_LOG2 to MAX_DECIM_LOG2. Clear accumulators and count.
  - Run -> Drain when !enable_i or !adc_ready_i. The partial accumulation is discarded.
  - Drain -> Idle when the FIFO is empty and no transfer is in flight.
  - Drain ignores valid_i but keeps presenting buffered words.
- Accumulation in Run, on each valid_i:
  - accA += sign-extended dataA_i; accB likewise.
  - count increments.
  - When count reaches 2^decim-1 on a valid_i, the next cycle registers avg = acc (including the current sample) >>> decim, arithmetic shift (floor), low 16 bits taken. Accumulators and count restart at that point.
  - decim=0 passes samples through unchanged.
- Latency: valid_i in cycle t -> FIFO write in cycle t+1 -> m_tvalid_o high in cycle t+2 when the FIFO was empty.
- FIFO:
  - Registered output; m_tdata_o is held stable while m_tvalid_o is high and m_tready_i is low.
  - A write while full is accepted only if a read occurs in the same cycle. Otherwise the new word is dropped and overflow_o is set next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
- overflow_o:
  - Cleared by rst_i or clear_ovf_i.
  - If clear and a drop occur in the same cycle, set wins.
  - Not cleared by leaving Run.
- rst_i mid-stream discards all buffered words with no output glitch; m_tvalid_o is 0 the next cycle.
- valid_i outside Run is ignored.

Optional Feature:
- Macro AD7383_DROP_COUNT_EN.
- Defined: adds output port drop_count_o (16 bits), counting dropped words, saturating at 16'hFFFF. Cleared with overflow_o under the same rules.
- Undefined: no port and no counter; only sticky overflow_o.

Decomposition:
- Package ad7383_pkg:
  - state enum (Idle, Run, Drain).
  - AD7383_SAMPLE_W=16 and the packed word type {a,b}.
  - Default MAX_DECIM_LOG2 constant.
  - Shared with the ADC interface for sample width.
- Sub-module ad7383_word_fifo: synchronous FIFO with registered output and full/empty/occupancy.
  - Parameters: width, depth.
  - The packer instantiates one.

Test Plan:
- decim=0, m_tready_i=1, valid_i every 20 cycles with A=16'h1234, B=16'hFEDC -> m_tdata_o=32'h1234FEDC, valid 2 cycles after each strobe, one cycle wide.
- decim=2, A samples 4, 8, -4, 1 (B all 16'h8000) -> single word: A=16'h0002 (floor of 9/4), B=16'h8000, emitted after the 4th strobe.
- decim=1, A samples -1, -2 -> A=16'hFFFE (floor of -1.5); verifies arithmetic shift.
- m_tready_i=0, decim=0, 6 strobes with FIFO_DEPTH=4:
  - First 4 words retained in order.
  - overflow_o=1 after the 5th strobe.
  - drop_count_o=2 with the macro defined.
  - Releasing ready drains exactly 4 words.
- Drop enable_i after 3 of 4 samples at decim=2 with 2 words buffered -> partial discarded; 2 words drained; busy_o falls after the last transfer; the next enable starts a fresh average.
- Assert rst_i with the FIFO full and m_tvalid_o high -> next cycle m_tvalid_o=0, overflow_o=0, busy_o=0.
